// File: rtl/bf16_pkg.sv
// Shared BF16 field widths, operand struct and accumulator FSM states.
package bf16_pkg;
    localparam int E = 8;
    localparam int M = 7;
    localparam logic [E-1:0] EXP_SPECIAL = 8'hFF;

    typedef struct packed {
        logic         s;
        logic [E-1:0] e;
        logic [M-1:0] m;
    } bf16_t;

    typedef enum logic [1:0] {IDLE, ACC, ADD, DONE} acc_state_e;
endpackage

// File: rtl/bf16_add.sv
// Combinational BF16 adder for normal operands; result truncated toward zero,
// exact cancellation or exponent underflow gives +0.
module bf16_add
    import bf16_pkg::*;
(
    input  logic         a_s,
    input  logic [E-1:0] a_e,
    input  logic [M-1:0] a_m,
    input  logic         b_s,
    input  logic [E-1:0] b_e,
    input  logic [M-1:0] b_m,
    output logic         s_o,
    output logic [E-1:0] e_o,
    output logic [M-1:0] m_o
);
    // Significand plus guard, round and sticky bits.
    localparam int W  = M + 4;
    localparam int TW = M + 1 + W;

    logic          swap;
    logic [E-1:0]  e_big, e_sml, d;
    logic [M:0]    sig_big, sig_sml;
    logic [W-1:0]  x_big, x_sml, diff, norm;
    logic [TW-1:0] tmp;
    logic [W:0]    sum;
    logic [3:0]    lz;
    logic          unused_bits;

    always_comb begin
        swap    = {b_e, b_m} > {a_e, a_m};
        e_big   = swap ? b_e : a_e;
        e_sml   = swap ? a_e : b_e;
        sig_big = {1'b1, swap ? b_m : a_m};
        sig_sml = {1'b1, swap ? a_m : b_m};
        d       = e_big - e_sml;
        x_big   = {sig_big, 3'b000};
        tmp     = {sig_sml, W'(0)} >> d;
        x_sml   = (d >= E'(W)) ? W'(1) : {tmp[TW-1 -: W-1], |tmp[TW-W:0]};

        sum  = {1'b0, x_big} + {1'b0, x_sml};
        diff = x_big - x_sml;
        lz   = 4'(W);
        for (int i = 0; i < W; i++)
            if (diff[i]) lz = 4'(W - 1 - i);
        norm = diff << lz;

        s_o = swap ? b_s : a_s;
        e_o = '0;
        m_o = '0;
        if (a_s == b_s) begin
            if (sum[W]) begin
                e_o = e_big + 1'b1;
                m_o = sum[W-1 -: M];
            end else begin
                e_o = e_big;
                m_o = sum[W-2 -: M];
            end
        end else if (diff == '0 || {1'b0, e_big} <= (E+1)'(lz)) begin
            s_o = 1'b0;
        end else begin
            e_o = e_big - E'(lz);
            m_o = norm[W-2 -: M];
        end
    end

    assign unused_bits = ^{sum[3:0], norm[2:0]};
endmodule

// File: rtl/bf16_acc.sv
// Packet accumulator: each BF16 beat is added into a registered running sum;
// the total, element count and exception flag are held until accepted.
module bf16_acc
    import bf16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [15:0]      out_data_o,
    output logic [CNT_W-1:0] out_cnt_o,
    output logic             out_exc_o
);
    acc_state_e       state_q, state_d;
    bf16_t            acc_q, op_q, sum, in_op;
    logic [CNT_W-1:0] cnt_q;
    logic             exc_q, last_q, in_exc;
    logic             add_s;
    logic [E-1:0]     add_e;
    logic [M-1:0]     add_m;

    assign in_op  = bf16_t'(in_data_i);
    assign in_exc = (in_op.e == EXP_SPECIAL);

    bf16_add u_add (
        .a_s(acc_q.s), .a_e(acc_q.e), .a_m(acc_q.m),
        .b_s(op_q.s),  .b_e(op_q.e),  .b_m(op_q.m),
        .s_o(add_s),   .e_o(add_e),   .m_o(add_m)
    );

    // Zero-exponent operands are treated as zero and skip the adder.
    always_comb begin
        sum = {add_s, add_e, add_m};
        if (op_q.e == '0)       sum = acc_q;
        else if (acc_q.e == '0) sum = op_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_d = in_last_i ? DONE : ACC;
            end
            ACC: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_d = ADD;
            end
            ADD:  state_d = last_q ? DONE : ACC;
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            exc_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid_i) begin
                    acc_q <= in_op;
                    cnt_q <= CNT_W'(1);
                    exc_q <= in_exc;
                end
                ACC: if (in_valid_i) begin
                    op_q   <= in_op;
                    last_q <= in_last_i;
                    exc_q  <= exc_q | in_exc;
                end
                ADD: begin
                    acc_q <= sum;
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_data_o = acc_q;
    assign out_cnt_o  = cnt_q;
    assign out_exc_o  = exc_q;
endmodule

// File: tb/tb_bf16_acc.sv
// Directed and random packets for bf16_acc, checked against a real-valued
// BF16 reference (truncating) with count saturation and exception tracking.
module tb_bf16_acc;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [15:0]      in_data_i = '0;
    logic             in_last_i = 1'b0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [15:0]      out_data_o;
    logic [CNT_W-1:0] out_cnt_o;
    logic             out_exc_o;

    int checks = 0;
    int errors = 0;

    bf16_acc #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .in_last_i(in_last_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_cnt_o(out_cnt_o), .out_exc_o(out_exc_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic real b2r(input logic [15:0] v);
        logic [15:0] t;
        real r;
        int  e;
        t = v;
        if (t[14:7] == 8'h00) return 0.0;
        r = 1.0 + real'(t[6:0]) / 128.0;
        e = int'(t[14:7]) - 127;
        for (int i = 0; i < e; i++) r = r * 2.0;
        for (int i = 0; i > e; i--) r = r / 2.0;
        return t[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2b(input real x);
        real a;
        int  e;
        int  m;
        if (x == 0.0) return 16'h0000;
        a = (x < 0.0) ? -x : x;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        if (e <= 0) return 16'h0000;
        m = int'($floor((a - 1.0) * 128.0));
        return {(x < 0.0), 8'(e), 7'(m)};
    endfunction

    function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
        if (b[14:7] == 8'h00) return a;
        if (a[14:7] == 8'h00) return b;
        return r2b(b2r(a) + b2r(b));
    endfunction

    function automatic logic [15:0] rand_op();
        int r;
        logic [7:0] e;
        r = int'($urandom_range(0, 15));
        if (r == 0)      e = 8'h00;
        else if (r == 1) e = 8'hFF;
        else             e = 8'($urandom_range(8'h78, 8'h87));
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = l;
        while (!in_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n >= 100), 32'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic run_pkt(input logic [15:0] d[$], input int gap_max, input int hold);
        logic [15:0] acc;
        int          cnt;
        logic        exc;
        acc = 16'h0000;
        cnt = 0;
        exc = 1'b0;
        for (int i = 0; i < d.size(); i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send(d[i], i == d.size() - 1);
            acc = (i == 0) ? d[i] : ref_sum(acc, d[i]);
            cnt = (cnt < CNT_MAX) ? cnt + 1 : cnt;
            exc = exc | (d[i][14:7] == 8'hFF);
            if (i > 0) chk("ready_low_in_add", 32'(in_ready_o), 32'(0));
        end
        if (d.size() == 1) begin
            chk("latency1_valid", 32'(out_valid_o), 32'(1));
        end else begin
            chk("latency2_early", 32'(out_valid_o), 32'(0));
            @(negedge clk);
            chk("latency2_valid", 32'(out_valid_o), 32'(1));
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid_o), 32'(1));
            chk("hold_ready", 32'(in_ready_o), 32'(0));
            chk("hold_cnt", 32'(out_cnt_o), 32'(cnt));
            if (!exc) chk("hold_data", 32'(out_data_o), 32'(acc));
        end
        if (!exc) chk("out_data", 32'(out_data_o), 32'(acc));
        chk("out_cnt", 32'(out_cnt_o), 32'(cnt));
        chk("out_exc", 32'(out_exc_o), 32'(exc));
        out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_i = 1'b0;
        chk("post_xfer_valid", 32'(out_valid_o), 32'(0));
        chk("post_xfer_ready", 32'(in_ready_o), 32'(1));
    endtask

    initial begin
        logic [15:0] q[$];

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_o), 32'(1));
        chk("rst_out_valid", 32'(out_valid_o), 32'(0));
        chk("rst_out_data", 32'(out_data_o), 32'(0));
        chk("rst_out_cnt", 32'(out_cnt_o), 32'(0));
        chk("rst_out_exc", 32'(out_exc_o), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        q = {16'h3F80, 16'h3F80};
        run_pkt(q, 0, 0);
        chk("pkt_1p1", 32'(out_data_o), 32'h4000);

        q = {16'h3F80, 16'h4000, 16'h3F00};
        run_pkt(q, 0, 0);
        chk("pkt_3p5", 32'(out_data_o), 32'h4060);

        q = {16'h3FC0};
        run_pkt(q, 0, 5);
        chk("pkt_single", 32'(out_data_o), 32'h3FC0);

        q = {16'h0000, 16'h3F80, 16'h0000, 16'h3F80};
        run_pkt(q, 0, 0);
        chk("pkt_zero_bypass", 32'(out_data_o), 32'h4000);

        q = {16'h7F80, 16'h3F80};
        run_pkt(q, 0, 0);
        chk("pkt_exc_flag", 32'(out_exc_o), 32'(1));
        q = {16'h3F80};
        run_pkt(q, 0, 0);
        chk("pkt_exc_cleared", 32'(out_exc_o), 32'(0));

        // Reset while the second beat is in the add cycle.
        send(16'h3F80, 1'b0);
        send(16'h4000, 1'b0);
        chk("pre_rst_ready", 32'(in_ready_o), 32'(0));
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(in_ready_o), 32'(1));
        chk("mid_rst_valid", 32'(out_valid_o), 32'(0));
        chk("mid_rst_data", 32'(out_data_o), 32'(0));
        chk("mid_rst_cnt", 32'(out_cnt_o), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        q = {16'h4000};
        run_pkt(q, 0, 0);
        chk("post_rst_pkt", 32'(out_data_o), 32'h4000);

        for (int p = 0; p < 40; p++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) q.push_back(rand_op());
            run_pkt(q, 2, int'($urandom_range(0, 3)));
        end

        // Long packet of positive normals drives the counter into saturation.
        q = {};
        for (int i = 0; i < 300; i++)
            q.push_back({1'b0, 8'($urandom_range(8'h78, 8'h87)), 7'($urandom_range(0, 127))});
        run_pkt(q, 0, 0);
        chk("cnt_saturated", 32'(out_cnt_o), 32'(CNT_MAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
